acc_pc_writeback: RTL and testbench

Writeback stage for the Simple CPU v1. It owns the accumulator (acc) and program counter (pc) registers and drives them onto the operand-A select path. It accepts ALU/operand results over a valid/ready handshake and routes each one into acc or pc. A one-entry holding buffer absorbs a write while the datapath is stalled. It also performs sequential PC increment and maintains a registered accumulator-zero flag.

---
 rtl/acc_pc_writeback_pkg.sv | 17 +
 rtl/acc_pc_writeback_wb_hold_buf.sv | 76 +++++++
 rtl/acc_pc_writeback.sv | 83 ++++++++
 tb/tb_acc_pc_writeback.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pc_writeback_pkg.sv
// Shared CPU definitions for the writeback stage and the operand-A select path.
// Holds the destination-select encoding so both consumers use the same values,
// the default datapath width, and the holding-buffer state type.
package acc_pc_writeback_pkg;

  localparam int   WB_WIDTH   = 8;

  // Destination select; also the operand-A select encoding.
  localparam logic WB_SEL_ACC = 1'b0;
  localparam logic WB_SEL_PC  = 1'b1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/acc_pc_writeback_wb_hold_buf.sv
// One-entry holding buffer for writeback results.
// Ports: clk/rst; wb_valid/wb_ready/wb_sel/wb_data result handshake; hold stall;
//        pending (buffer full); commit_vld/commit_sel/commit_dat write to apply this edge.
// Latency: a result commits on its accept edge when not stalled, else on the first unstalled edge.
// Backpressure: wb_ready drops while the buffer is full, including the edge that drains it.
module wb_hold_buf
  import acc_pc_writeback_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic             wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             hold,
  output logic             pending,
  output logic             commit_vld,
  output logic             commit_sel,
  output logic [WIDTH-1:0] commit_dat
);

  buf_state_e       state_q, state_d;
  logic             buf_sel_q, buf_sel_d;
  logic [WIDTH-1:0] buf_dat_q, buf_dat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUF_EMPTY;
      buf_sel_q <= 1'b0;
      buf_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      buf_sel_q <= buf_sel_d;
      buf_dat_q <= buf_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_sel_d  = buf_sel_q;
    buf_dat_d  = buf_dat_q;
    commit_vld = 1'b0;
    commit_sel = wb_sel;
    commit_dat = wb_data;
    case (state_q)
      BUF_EMPTY: begin
        if (wb_valid) begin
          if (hold) begin
            // Stalled: park the result instead of committing it.
            state_d   = BUF_FULL;
            buf_sel_d = wb_sel;
            buf_dat_d = wb_data;
          end else begin
            commit_vld = 1'b1;
          end
        end
      end
      BUF_FULL: begin
        // Drain on the first unstalled edge; no new result is taken on it.
        if (!hold) begin
          commit_vld = 1'b1;
          commit_sel = buf_sel_q;
          commit_dat = buf_dat_q;
          state_d    = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign pending  = (state_q == BUF_FULL);
  assign wb_ready = (state_q == BUF_EMPTY);

endmodule

// File: rtl/acc_pc_writeback.sv
// Writeback stage: owns acc and pc, routes results into them, and increments pc.
// Ports: clk/rst; wb_valid/wb_ready/wb_sel/wb_data result handshake; hold stall;
//        pc_inc increment request; acc/pc/acc_zero/pending registered state.
// Latency: one cycle from commit edge to register output.
// Backpressure: wb_ready = !pending, via the one-entry holding buffer.
module acc_pc_writeback
  import acc_pc_writeback_pkg::*;
#(
  parameter int               WIDTH   = WB_WIDTH,
  parameter logic [WIDTH-1:0] ACC_RST = '0,
  parameter logic [WIDTH-1:0] PC_RST  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic             wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             hold,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] pc,
  output logic             acc_zero,
  output logic             pending
);

  logic             commit_vld;
  logic             commit_sel;
  logic [WIDTH-1:0] commit_dat;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             zero_q, zero_d;

  wb_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_sel     (wb_sel),
    .wb_data    (wb_data),
    .hold       (hold),
    .pending    (pending),
    .commit_vld (commit_vld),
    .commit_sel (commit_sel),
    .commit_dat (commit_dat)
  );

  always_comb begin
    acc_d  = acc_q;
    pc_d   = pc_q;
    zero_d = zero_q;
    // Increment first so that a pc write on the same edge overrides it.
    if (!hold && pc_inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
    if (commit_vld) begin
      if (commit_sel == WB_SEL_PC) begin
        pc_d = commit_dat;
      end else begin
        acc_d  = commit_dat;
        zero_d = (commit_dat == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= ACC_RST;
      pc_q   <= PC_RST;
      zero_q <= (ACC_RST == '0);
    end else begin
      acc_q  <= acc_d;
      pc_q   <= pc_d;
      zero_q <= zero_d;
    end
  end

  assign acc      = acc_q;
  assign pc       = pc_q;
  assign acc_zero = zero_q;

endmodule

// File: tb/tb_acc_pc_writeback.sv
module tb_acc_pc_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_valid, wb_ready, wb_sel, hold, pc_inc;
  logic [7:0] wb_data, acc, pc;
  logic       acc_zero, pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acc_pc_writeback dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_sel   (wb_sel),
    .wb_data  (wb_data),
    .hold     (hold),
    .pc_inc   (pc_inc),
    .acc      (acc),
    .pc       (pc),
    .acc_zero (acc_zero),
    .pending  (pending)
  );

  typedef struct packed {
    logic       hold, vld, sel;
    logic [7:0] dat;
    logic       inc;
    logic [7:0] eacc, epc;
    logic       ez, ep;
  } vec_t;

  typedef struct packed {
    logic [7:0] acc, pc;
    logic       z, p;
  } exp_t;

  vec_t tbl [20];
  exp_t sb [$];
  logic [7:0] accq [$];

  // Reference state for the random section.
  logic [7:0] m_acc, m_pc, m_bdat;
  logic       m_z, m_p, m_bsel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v, input logic s, input logic [7:0] d, input logic i);
    hold = h; wb_valid = v; wb_sel = s; wb_data = d; pc_inc = i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_acc"}, acc, e.acc);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_zero"}, acc_zero, e.z);
      chk({tag, "_pend"}, pending, e.p);
    end
  endtask

  task automatic model_step();
    logic pcw;
    pcw = 1'b0;
    if (!hold && pc_inc) m_pc = m_pc + 8'd1;
    if (!m_p) begin
      if (wb_valid) begin
        if (hold) begin
          m_p = 1'b1; m_bsel = wb_sel; m_bdat = wb_data;
        end else if (wb_sel) begin
          m_pc = wb_data;
        end else begin
          m_acc = wb_data; m_z = (wb_data == 8'h00);
        end
      end
    end else if (!hold) begin
      m_p = 1'b0;
      if (m_bsel) m_pc = m_bdat;
      else begin m_acc = m_bdat; m_z = (m_bdat == 8'h00); end
    end
    pcw = pcw;
  endtask

  initial begin
    //               hold vld sel dat   inc  acc    pc    z  p
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 8'hFE, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 8'h00, 8'h80, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00, 8'h05, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 8'h11, 8'h06, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 8'h20, 1'b0, 8'h11, 8'h06, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h20, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h11, 8'h20, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h21, 1'b1, 1'b0};

    // Power-on reset.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(); step();
    chk("rst_acc", acc, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_zero", acc_zero, 1'b1);
    chk("rst_pend", pending, 1'b0);
    chk("rst_rdy", wb_ready, 1'b1);
    rst = 1'b0;
    step();

    // Table vectors: expectation queued when driven, checked after the edge.
    begin
      logic prev_p;
      prev_p = 1'b0;
      for (int i = 0; i < 20; i++) begin
        drive(tbl[i].hold, tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].inc);
        #1;
        chk($sformatf("v%0d_rdy", i), wb_ready, !prev_p);
        sb.push_back('{tbl[i].eacc, tbl[i].epc, tbl[i].ez, tbl[i].ep});
        step();
        compare_pop($sformatf("v%0d", i));
        prev_p = tbl[i].ep;
      end
    end

    // Held buffer stays put across several stalled cycles.
    drive(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("hold%0d_pc", k), pc, 8'h21);
      chk($sformatf("hold%0d_rdy", k), wb_ready, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("drain_pc", pc, 8'h40);
    chk("drain_pend", pending, 1'b0);
    chk("drain_rdy", wb_ready, 1'b1);

    // Mid-cycle reset while the buffer is full.
    drive(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0); step();
    drive(1'b0, 1'b1, 1'b1, 8'h10, 1'b0); step();
    drive(1'b1, 1'b1, 1'b0, 8'h55, 1'b0); step();
    chk("pre_rst_acc", acc, 8'h3C);
    chk("pre_rst_pc", pc, 8'h10);
    chk("pre_rst_pend", pending, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_acc", acc, 8'h00);
    chk("mid_rst_pc", pc, 8'h00);
    chk("mid_rst_zero", acc_zero, 1'b1);
    chk("mid_rst_pend", pending, 1'b0);
    chk("mid_rst_rdy", wb_ready, 1'b1);
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("post_rst_acc", acc, 8'h00);
    chk("post_rst_pend", pending, 1'b0);

    // Back-to-back acc writes with hold pattern 1,0,0,0...
    begin
      logic [7:0] vals [3];
      logic [7:0] prev_acc;
      int idx, landed, cyc;
      logic acc_ok;
      vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
      idx = 0; landed = 0; cyc = 0;
      prev_acc = acc;
      while ((landed < 3) && (cyc < 20)) begin
        if (idx < 3) drive((cyc == 0), 1'b1, 1'b0, vals[idx], 1'b0);
        else         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        acc_ok = wb_valid && wb_ready;
        if (acc_ok) accq.push_back(vals[idx]);
        step();
        if (acc_ok) idx++;
        if (acc !== prev_acc) begin
          landed++;
          if (accq.size() == 0) chk("b2b_spurious", acc, prev_acc);
          else chk($sformatf("b2b_land%0d", landed), acc, accq.pop_front());
          prev_acc = acc;
        end
        cyc++;
      end
      chk("b2b_landed", landed, 3);
      chk("b2b_accepted", idx, 3);
      chk("b2b_leftover", accq.size(), 0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) step();
      chk("b2b_final_acc", acc, 8'h03);
    end

    // Random traffic against the reference state.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_acc = 8'h00; m_pc = 8'h00; m_z = 1'b1; m_p = 1'b0; m_bsel = 1'b0; m_bdat = 8'h00;
    for (int r = 0; r < 300; r++) begin
      drive(($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)), $urandom_range(0, 1));
      #1;
      if (wb_ready !== !m_p) chk($sformatf("r%0d_rdy", r), wb_ready, !m_p);
      model_step();
      sb.push_back('{m_acc, m_pc, m_z, m_p});
      step();
      compare_pop($sformatf("r%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
